// File: rtl/memoria_ram.sv
// Single-port word RAM with a registered read port, a per-word "written since reset" bitmap
// and one-cycle status pulses for reads, read/write conflicts and reads of unwritten words.
module memoria_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd,
  input  logic              we,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [DATA_W-1:0] dataInMem,
  output logic [DATA_W-1:0] dataOutMem,
  output logic              dataValid,
  output logic              conflito,
  output logic              naoInicializado
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    OCIOSO,
    LEITURA,
    ESCRITA,
    CONFLITO
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]    written_q, written_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                naoInit_q, naoInit_d;

  always_comb begin
    state_d   = OCIOSO;
    written_d = written_q;
    dout_d    = dout_q;
    naoInit_d = 1'b0;
    unique case ({rd, we})
      2'b10: begin
        state_d = LEITURA;
        if (written_q[endereco]) begin
          dout_d = mem_q[endereco];
        end else begin
          dout_d    = '0;
          naoInit_d = 1'b1;
        end
      end
      2'b01: begin
        state_d             = ESCRITA;
        written_d[endereco] = 1'b1;
      end
      2'b11: begin
        state_d             = CONFLITO;
        written_d[endereco] = 1'b1;
        dout_d              = dataInMem;
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= OCIOSO;
      written_q <= '0;
      dout_q    <= '0;
      naoInit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      written_q <= written_d;
      dout_q    <= dout_d;
      naoInit_q <= naoInit_d;
    end
  end

  // Storage is never cleared; the bitmap hides stale contents. Gating on reset_n drops writes under reset.
  always_ff @(posedge clock) begin
    if (reset_n && we) begin
      mem_q[endereco] <= dataInMem;
    end
  end

  assign dataOutMem      = dout_q;
  assign dataValid       = (state_q == LEITURA) || (state_q == CONFLITO);
  assign conflito        = (state_q == CONFLITO);
  assign naoInicializado = naoInit_q;

endmodule

// File: tb/tb_memoria_ram.sv
// Directed self-checking bench for memoria_ram: one task per scenario, hand-computed expectations.
module tb_memoria_ram;

  logic       clock;
  logic       reset_n;
  logic       rd;
  logic       we;
  logic [3:0] endereco;
  logic [7:0] dataInMem;
  logic [7:0] dataOutMem;
  logic       dataValid;
  logic       conflito;
  logic       naoInicializado;

  int checks;
  int errors;

  memoria_ram #(.ADDR_W(4), .DATA_W(8)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .rd              (rd),
    .we              (we),
    .endereco        (endereco),
    .dataInMem       (dataInMem),
    .dataOutMem      (dataOutMem),
    .dataValid       (dataValid),
    .conflito        (conflito),
    .naoInicializado (naoInicializado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d);
    rd        = r;
    we        = w;
    endereco  = a;
    dataInMem = d;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    #2;
    checks++;
    if (dataOutMem !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", dataOutMem); end
    checks++;
    if ({dataValid, conflito, naoInicializado} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b want 000", {dataValid, conflito, naoInicializado});
    end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_uninit_read();
    drive(1'b1, 1'b0, 4'd3, 8'hFF);
    tick();
    checks++;
    if (dataOutMem !== 8'h00) begin errors++; $display("FAIL uninit_dout: got %h want 00", dataOutMem); end
    checks++;
    if ({dataValid, conflito, naoInicializado} !== 3'b101) begin
      errors++; $display("FAIL uninit_flags: got %b want 101", {dataValid, conflito, naoInicializado});
    end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    checks++;
    if ({dataValid, conflito, naoInicializado} !== 3'b000) begin
      errors++; $display("FAIL uninit_pulse_end: got %b want 000", {dataValid, conflito, naoInicializado});
    end
  endtask

  task automatic test_write_read();
    drive(1'b0, 1'b1, 4'd5, 8'hA7);
    tick();
    checks++;
    if (dataValid !== 1'b0) begin errors++; $display("FAIL wr_no_valid: got %b want 0", dataValid); end
    drive(1'b1, 1'b0, 4'd5, 8'h00);
    tick();
    checks++;
    if (dataOutMem !== 8'hA7) begin errors++; $display("FAIL wr_rd5_dout: got %h want a7", dataOutMem); end
    checks++;
    if ({dataValid, conflito, naoInicializado} !== 3'b100) begin
      errors++; $display("FAIL wr_rd5_flags: got %b want 100", {dataValid, conflito, naoInicializado});
    end
  endtask

  task automatic test_conflict();
    drive(1'b1, 1'b1, 4'd2, 8'h3C);
    tick();
    checks++;
    if (dataOutMem !== 8'h3C) begin errors++; $display("FAIL confl_dout: got %h want 3c", dataOutMem); end
    checks++;
    if ({dataValid, conflito, naoInicializado} !== 3'b110) begin
      errors++; $display("FAIL confl_flags: got %b want 110", {dataValid, conflito, naoInicializado});
    end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
    checks++;
    if (conflito !== 1'b0) begin errors++; $display("FAIL confl_pulse_end: got %b want 0", conflito); end
    drive(1'b1, 1'b0, 4'd2, 8'h00);
    tick();
    checks++;
    if (dataOutMem !== 8'h3C) begin errors++; $display("FAIL confl_readback: got %h want 3c", dataOutMem); end
    checks++;
    if (naoInicializado !== 1'b0) begin errors++; $display("FAIL confl_readback_nao: got %b want 0", naoInicializado); end
  endtask

  task automatic test_boundary();
    drive(1'b0, 1'b1, 4'd0, 8'h11);
    tick();
    drive(1'b0, 1'b1, 4'd15, 8'hEE);
    tick();
    drive(1'b1, 1'b0, 4'd0, 8'h00);
    tick();
    checks++;
    if (dataOutMem !== 8'h11) begin errors++; $display("FAIL bound_addr0: got %h want 11", dataOutMem); end
    drive(1'b1, 1'b0, 4'd15, 8'h00);
    tick();
    checks++;
    if (dataOutMem !== 8'hEE) begin errors++; $display("FAIL bound_addr15: got %h want ee", dataOutMem); end
    checks++;
    if (naoInicializado !== 1'b0) begin errors++; $display("FAIL bound_nao: got %b want 0", naoInicializado); end
  endtask

  task automatic test_idle_hold();
    // Idle with garbage address/data: output must hold and nothing may be written
    drive(1'b0, 1'b0, 4'd8, 8'h5A);
    tick();
    checks++;
    if (dataOutMem !== 8'hEE) begin errors++; $display("FAIL idle_hold: got %h want ee", dataOutMem); end
    checks++;
    if (dataValid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", dataValid); end
    drive(1'b1, 1'b0, 4'd8, 8'h00);
    tick();
    checks++;
    if ({dataOutMem, naoInicializado} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL idle_no_write: got %h/%b want 00/1", dataOutMem, naoInicializado);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [4];
    vals[0] = 8'h21; vals[1] = 8'h43; vals[2] = 8'h65; vals[3] = 8'h87;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 4'(10 + i), vals[i]);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'(10 + i), 8'h00);
      tick();
      checks++;
      if ({dataOutMem, dataValid, naoInicializado} !== {vals[i], 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL b2b_rd%0d: got %h/%b/%b want %h/1/0", 10 + i, dataOutMem, dataValid, naoInicializado, vals[i]);
      end
    end
    // Write then immediately read the same word: must see the fresh value
    drive(1'b0, 1'b1, 4'd10, 8'hC3);
    tick();
    drive(1'b1, 1'b0, 4'd10, 8'h00);
    tick();
    checks++;
    if (dataOutMem !== 8'hC3) begin errors++; $display("FAIL b2b_fresh: got %h want c3", dataOutMem); end
  endtask

  task automatic test_short_reset();
    drive(1'b0, 1'b1, 4'd7, 8'h55);
    tick();
    drive(1'b1, 1'b0, 4'd7, 8'h00);
    tick();
    checks++;
    if (dataOutMem !== 8'h55) begin errors++; $display("FAIL sr_pre: got %h want 55", dataOutMem); end
    drive(1'b0, 1'b0, 4'd7, 8'h00);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({dataOutMem, dataValid} !== {8'h00, 1'b0}) begin
      errors++; $display("FAIL sr_async: got %h/%b want 00/0", dataOutMem, dataValid);
    end
    #2;
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 4'd7, 8'h00);
    tick();
    checks++;
    if ({dataOutMem, dataValid, naoInicializado} !== {8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL sr_read7: got %h/%b/%b want 00/1/1", dataOutMem, dataValid, naoInicializado);
    end
  endtask

  task automatic test_reset_during_write();
    drive(1'b0, 1'b1, 4'd9, 8'h99);
    reset_n = 1'b0;
    tick();
    checks++;
    if ({dataValid, conflito, naoInicializado} !== 3'b000) begin
      errors++; $display("FAIL rdw_flags: got %b want 000", {dataValid, conflito, naoInicializado});
    end
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 4'd9, 8'h00);
    tick();
    checks++;
    if ({dataOutMem, dataValid, naoInicializado} !== {8'h00, 1'b1, 1'b1}) begin
      errors++; $display("FAIL rdw_read9: got %h/%b/%b want 00/1/1", dataOutMem, dataValid, naoInicializado);
    end
    drive(1'b0, 1'b0, 4'd0, 8'h00);
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_uninit_read();
    test_write_read();
    test_conflict();
    test_boundary();
    test_idle_hold();
    test_back_to_back();
    test_short_reset();
    test_reset_during_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/memoria_ram.md
MEMORIA_RAM -- requirements
Module: memoria_ram

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, address width; depth is 2^ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 8, word width.
REQ-003 SHALL have port clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port rd  input  1  read request, sampled on the rising edge.
REQ-006 SHALL have port we  input  1  write request, sampled on the rising edge.
REQ-007 SHALL have port endereco  input  ADDR_W  word address (the control unit's operand field).
REQ-008 SHALL have port dataInMem  input  DATA_W  write data.
REQ-009 SHALL have port dataOutMem  output  DATA_W  registered read data.
REQ-010 SHALL have port dataValid  output  1  one-cycle pulse marking a fresh dataOutMem.
REQ-011 SHALL have port conflito  output  1  one-cycle pulse when rd and we were both sampled high.
REQ-012 SHALL have port naoInicializado  output  1  one-cycle pulse when a read hit a word not written since reset.

Function
REQ-013 SHALL hold a DATA_W x 2^ADDR_W storage array plus a 2^ADDR_W-bit written-bitmap, one bit per word.
REQ-014 SHALL implement a state register with states OCIOSO, LEITURA, ESCRITA, CONFLITO; the state reflects the operation sampled on the previous edge.
REQ-015 SHALL compute the next state each edge from {rd,we}: 00->OCIOSO, 10->LEITURA, 01->ESCRITA, 11->CONFLITO, from any state.
REQ-016 SHALL, on an edge with we=1, write dataInMem to array[endereco] and set bitmap[endereco].
REQ-017 SHALL, on an edge with rd=1 and we=0, load dataOutMem with array[endereco] if bitmap[endereco]=1, else with 0.
REQ-018 SHALL read with latency 1: a request sampled at edge N gives dataOutMem and dataValid=1 after edge N, for exactly one cycle.
REQ-019 SHALL pulse naoInicializado in the same cycle as dataValid when the read word had bitmap=0.
REQ-020 SHALL, on an edge with rd=1 and we=1, perform the write and load dataOutMem with dataInMem (write-through).
REQ-021 SHALL, on that same rd=1, we=1 edge, pulse dataValid and conflito for one cycle, with naoInicializado=0.
REQ-022 SHALL hold dataOutMem unchanged on edges without rd=1; dataValid, conflito and naoInicializado return to 0.
REQ-023 SHALL return the newly written value when a read follows a write to the same address on the next edge (no stale data).
REQ-024 SHALL accept back-to-back requests every cycle with no stall.
REQ-025 SHALL ignore endereco and dataInMem when rd=0 and we=0.
REQ-026 SHALL use all ADDR_W address bits (no aliasing); addresses 0 and 2^ADDR_W-1 are valid.

Reset
REQ-027 SHALL, while reset_n=0, force dataOutMem=0, dataValid=0, conflito=0, naoInicializado=0, state=OCIOSO and the whole bitmap to 0, independent of clock.
REQ-028 SHALL NOT clear the storage array on reset; the cleared bitmap makes all words read as 0 with naoInicializado=1.
REQ-029 SHALL drop any write or read in flight when reset asserts mid-operation: no array update, no dataValid pulse.
REQ-030 SHALL act on the first rising edge after reset_n deasserts when rd or we is high at that edge.

Verification
REQ-031 SHALL cover: reset, then rd=1, endereco=3 -> after 1 edge dataOutMem=0x00, dataValid=1, naoInicializado=1.
REQ-032 SHALL cover: we=1, endereco=5, dataInMem=0xA7; next edge rd=1, endereco=5 -> dataOutMem=0xA7, dataValid=1, naoInicializado=0.
REQ-033 SHALL cover: rd=1, we=1, endereco=2, dataInMem=0x3C -> dataOutMem=0x3C, conflito=1, dataValid=1; later read of 2 -> 0x3C.
REQ-034 SHALL cover: write 0x11 to address 0 and 0xEE to address 15, then read both -> 0x11 and 0xEE, no aliasing.
REQ-035 SHALL cover: write 0x55 to address 7, pulse reset_n low for less than a clock period, read 7 -> 0x00, naoInicializado=1.
REQ-036 SHALL cover: reset_n asserted in the same cycle as we=1 for address 9 with 0x99, then after release read 9 -> 0x00, naoInicializado=1.
